om_result_collector: RTL and testbench

- Sits directly downstream of the 19x19 detection stage.
- Consumes the ANN classifier's per-stage outputs: output-memory write strobe, address and data, stage-finish and pass.
- Forwards output-memory writes through a one-cycle register, tracks the cascade stage reached by the current window, and pushes accepted windows (index plus score) into a result FIFO for host readout.
- Appends an end-of-frame marker carrying the face count.

---
 rtl/om_result_collector_pkg.sv | 27 ++
 rtl/om_result_collector_fifo.sv | 46 ++++
 rtl/om_result_collector.sv | 128 ++++++++++++
 tb/tb_om_result_collector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/om_result_collector_pkg.sv
// om_result_collector_pkg: shared tags, FSM states, entry layout and entry builders for the result collector
package om_result_collector_pkg;
    localparam int OM_AW = 13;
    localparam int OM_DW = 32;
    localparam int SCORE_W = 16;
    localparam int TAG_LSB = 30;
    localparam int WIN_LSB = 17;
    localparam int SCORE_LSB = 0;
    localparam logic [1:0] TAG_FACE = 2'b01;
    localparam logic [1:0] TAG_EOF = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MARK} state_t;
    function automatic logic [OM_DW-1:0] face_entry(input logic [OM_AW-1:0] win, input logic [SCORE_W-1:0] score);
        logic [OM_DW-1:0] e;
        e = '0;
        e[TAG_LSB +: 2] = TAG_FACE;
        e[WIN_LSB +: OM_AW] = win;
        e[SCORE_LSB +: SCORE_W] = score;
        return e;
    endfunction
    function automatic logic [OM_DW-1:0] eof_entry(input logic [OM_AW-1:0] count);
        logic [OM_DW-1:0] e;
        e = '0;
        e[TAG_LSB +: 2] = TAG_EOF;
        e[0 +: OM_AW] = count;
        return e;
    endfunction
endpackage

// File: rtl/om_result_collector_fifo.sv
// res_fifo: synchronous non-show-ahead FIFO (iClk, iReset, wrreq, data, rdreq -> q, empty, full, usedw)
module res_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 64,
    parameter int AW = 6
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          wrreq,
    input  logic [W-1:0]  data,
    input  logic          rdreq,
    output logic [W-1:0]  q,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   usedw
);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic [W-1:0] r_q;
    logic w_push, w_pop;
    assign empty = r_cnt == '0;
    assign full = r_cnt == (AW+1)'(DEPTH);
    assign usedw = r_cnt;
    assign q = r_q;
    assign w_push = wrreq && !full;
    assign w_pop = rdreq && !empty;
    always_ff @(posedge iClk) begin
        if (w_push) r_mem[r_wp] <= data;
    end
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
            r_q <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
                r_q <= r_mem[r_rp];
            end
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/om_result_collector.sv
// om_result_collector: registers OM writes, tracks cascade stage per window, queues accepted windows and end-of-frame markers for host readout
module om_result_collector
    import om_result_collector_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int FIFO_DEPTH = 64,
    parameter int FIFO_AW = 6
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iStart_Frame,
    input  logic                iFrame_End,
    input  logic                iWrreq_OM,
    input  logic [OM_AW-1:0]    iAddr_OM,
    input  logic [OM_DW-1:0]    iData_OM,
    input  logic                iFinish_Stage,
    input  logic                iPass,
    input  logic                iRdreq_RES,
    output logic                oWren_OM,
    output logic [OM_AW-1:0]    oWraddr_OM,
    output logic [OM_DW-1:0]    oWrdata_OM,
    output logic                oNext_Window,
    output logic [2:0]          oStage,
    output logic [OM_DW-1:0]    oData_RES,
    output logic                oEmpty_RES,
    output logic [FIFO_AW:0]    oUsedw_RES,
    output logic [OM_AW-1:0]    oFace_Count,
    output logic                oOverflow,
    output logic                oFrame_Done
);
    localparam logic [2:0] LAST = 3'(NUM_STAGES - 1);
    state_t r_state, w_next;
    logic r_wren, r_next_win, r_done, r_ovf;
    logic [OM_AW-1:0] r_wraddr, r_win, r_count;
    logic [OM_DW-1:0] r_wrdata;
    logic [SCORE_W-1:0] r_score;
    logic [2:0] r_stage;
    logic w_full, w_push, w_accept, w_fail, w_adv, w_mark, w_clear;
    logic [OM_AW-1:0] w_win;
    logic [SCORE_W-1:0] w_score;
    logic [OM_DW-1:0] w_entry;
    assign w_win = iWrreq_OM ? iAddr_OM : r_win;
    assign w_score = iWrreq_OM ? iData_OM[SCORE_W-1:0] : r_score;
    assign w_push = w_mark || (w_accept && !w_full);
    assign w_entry = w_mark ? eof_entry(r_count) : face_entry(w_win, w_score);
    always_comb begin
        w_next = r_state;
        w_accept = 1'b0;
        w_fail = 1'b0;
        w_adv = 1'b0;
        w_mark = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clear = iStart_Frame;
                w_next = iStart_Frame ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_fail = iFinish_Stage && !iPass;
                w_adv = iFinish_Stage && iPass && r_stage < LAST;
                w_accept = iFinish_Stage && iPass && r_stage >= LAST;
                w_next = iFrame_End ? S_MARK : S_RUN;
            end
            S_MARK: begin
                w_mark = !w_full;
                w_next = w_full ? S_MARK : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge iClk) begin
        if (iReset) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_wren <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
            r_score <= '0;
            r_win <= '0;
            r_next_win <= 1'b0;
            r_done <= 1'b0;
            r_stage <= '0;
            r_count <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_wren <= iWrreq_OM;
            r_wraddr <= iAddr_OM;
            r_wrdata <= iData_OM;
            if (iWrreq_OM) begin
                r_score <= iData_OM[SCORE_W-1:0];
                r_win <= iAddr_OM;
            end
            r_next_win <= w_accept || w_fail;
            r_done <= w_mark;
            if (w_clear) begin
                r_stage <= '0;
                r_count <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_adv) r_stage <= r_stage + 1'b1;
                if (w_accept || w_fail) r_stage <= '0;
                if (w_accept && r_count != '1) r_count <= r_count + 1'b1;
                if (w_accept && w_full) r_ovf <= 1'b1;
            end
        end
    end
    res_fifo #(.W(OM_DW), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .iClk(iClk),
        .iReset(iReset),
        .wrreq(w_push),
        .data(w_entry),
        .rdreq(iRdreq_RES),
        .q(oData_RES),
        .empty(oEmpty_RES),
        .full(w_full),
        .usedw(oUsedw_RES)
    );
    assign oWren_OM = r_wren;
    assign oWraddr_OM = r_wraddr;
    assign oWrdata_OM = r_wrdata;
    assign oNext_Window = r_next_win;
    assign oStage = r_stage;
    assign oFace_Count = r_count;
    assign oOverflow = r_ovf;
    assign oFrame_Done = r_done;
endmodule

// File: tb/tb_om_result_collector.sv
// tb_om_result_collector: directed stimulus against a queue-based behavioural model of the result collector
module tb_om_result_collector;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic iReset, iStart_Frame, iFrame_End, iWrreq_OM, iFinish_Stage, iPass, iRdreq_RES;
    logic [12:0] iAddr_OM;
    logic [31:0] iData_OM;
    logic oWren_OM, oNext_Window, oEmpty_RES, oOverflow, oFrame_Done;
    logic [12:0] oWraddr_OM, oFace_Count;
    logic [31:0] oWrdata_OM, oData_RES;
    logic [2:0] oStage;
    logic [6:0] oUsedw_RES;
    om_result_collector dut (
        .iClk(clk), .iReset(iReset), .iStart_Frame(iStart_Frame), .iFrame_End(iFrame_End),
        .iWrreq_OM(iWrreq_OM), .iAddr_OM(iAddr_OM), .iData_OM(iData_OM),
        .iFinish_Stage(iFinish_Stage), .iPass(iPass), .iRdreq_RES(iRdreq_RES),
        .oWren_OM(oWren_OM), .oWraddr_OM(oWraddr_OM), .oWrdata_OM(oWrdata_OM),
        .oNext_Window(oNext_Window), .oStage(oStage), .oData_RES(oData_RES),
        .oEmpty_RES(oEmpty_RES), .oUsedw_RES(oUsedw_RES), .oFace_Count(oFace_Count),
        .oOverflow(oOverflow), .oFrame_Done(oFrame_Done)
    );
    logic [31:0] q_m[$];
    int mode_m = 0, stage_m = 0, count_m = 0;
    bit ovf_m = 0;
    logic [15:0] sc_m = '0;
    logic [12:0] win_m = '0;
    logic e_wren = 0, e_nw = 0, e_empty = 1, e_ovf = 0, e_done = 0;
    logic [12:0] e_addr = '0;
    logic [31:0] e_wdata = '0, e_data = '0;
    int e_stage = 0, e_used = 0, e_count = 0;
    int nvec = 0, nfail = 0;
    bit chk_en = 0;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask
    always @(negedge clk) if (chk_en) begin
        chk("wren", 32'(oWren_OM), 32'(e_wren));
        chk("wraddr", 32'(oWraddr_OM), 32'(e_addr));
        chk("wrdata", oWrdata_OM, e_wdata);
        chk("next_window", 32'(oNext_Window), 32'(e_nw));
        chk("stage", 32'(oStage), 32'(e_stage));
        chk("rd_data", oData_RES, e_data);
        chk("empty", 32'(oEmpty_RES), 32'(e_empty));
        chk("usedw", 32'(oUsedw_RES), 32'(e_used));
        chk("face_count", 32'(oFace_Count), 32'(e_count));
        chk("overflow", 32'(oOverflow), 32'(e_ovf));
        chk("frame_done", 32'(oFrame_Done), 32'(e_done));
    end
    task automatic cycle();
        int old;
        bit popf, nw, fd;
        logic [31:0] d;
        nw = 0;
        fd = 0;
        d = e_data;
        if (iReset) begin
            q_m.delete();
            mode_m = 0; stage_m = 0; count_m = 0; ovf_m = 0; sc_m = '0; win_m = '0; d = '0;
        end else begin
            old = q_m.size();
            popf = iRdreq_RES && old > 0;
            if (iWrreq_OM) begin
                sc_m = iData_OM[15:0];
                win_m = iAddr_OM;
            end
            if (mode_m == 0) begin
                if (iStart_Frame) begin
                    mode_m = 1; count_m = 0; stage_m = 0; ovf_m = 0;
                end
            end else if (mode_m == 1) begin
                if (iFinish_Stage) begin
                    if (!iPass) begin
                        stage_m = 0; nw = 1;
                    end else if (stage_m < 4) begin
                        stage_m++;
                    end else begin
                        if (count_m < 8191) count_m++;
                        if (old < 64) q_m.push_back({2'b01, win_m, 1'b0, sc_m});
                        else ovf_m = 1;
                        stage_m = 0; nw = 1;
                    end
                end
                if (iFrame_End) mode_m = 2;
            end else if (old < 64) begin
                q_m.push_back({2'b11, 17'b0, 13'(count_m)});
                fd = 1;
                mode_m = 0;
            end
            if (popf) d = q_m.pop_front();
        end
        @(posedge clk);
        e_wren = iReset ? 1'b0 : iWrreq_OM;
        e_addr = iReset ? '0 : iAddr_OM;
        e_wdata = iReset ? '0 : iData_OM;
        e_nw = nw; e_done = fd; e_stage = stage_m; e_count = count_m; e_ovf = ovf_m;
        e_data = d; e_used = q_m.size(); e_empty = q_m.size() == 0;
        @(negedge clk);
    endtask
    task automatic clr();
        iReset = 0; iStart_Frame = 0; iFrame_End = 0; iWrreq_OM = 0; iFinish_Stage = 0;
        iPass = 0; iRdreq_RES = 0; iAddr_OM = '0; iData_OM = '0;
    endtask
    task automatic step(input bit pass, input bit wr, input logic [12:0] a, input logic [31:0] d, input bit fe, input bit rd);
        iFinish_Stage = 1; iPass = pass; iWrreq_OM = wr; iAddr_OM = a; iData_OM = d;
        iFrame_End = fe; iRdreq_RES = rd;
        cycle();
        clr();
    endtask
    task automatic accept(input logic [12:0] a, input logic [31:0] d, input bit fe, input bit rd);
        step(1, 1, a ^ 13'h1, 32'h1111_2222, 0, 0);
        repeat (3) step(1, 0, '0, '0, 0, 0);
        step(1, 1, a, d, fe, rd);
    endtask
    task automatic pop();
        iRdreq_RES = 1;
        cycle();
        clr();
    endtask
    task automatic start();
        iStart_Frame = 1;
        cycle();
        clr();
    endtask
    initial begin
        clr();
        iReset = 1;
        chk_en = 1;
        repeat (2) cycle();
        clr();
        chk("reset_empty", 32'(oEmpty_RES), 32'd1);
        chk("reset_wren", 32'(oWren_OM), 32'd0);
        pop();
        chk("pop_empty_data", oData_RES, 32'd0);
        start();
        accept(13'h012, 32'h0000_ABCD, 0, 0);
        chk("accept_nw", 32'(oNext_Window), 32'd1);
        chk("accept_count", 32'(oFace_Count), 32'd1);
        pop();
        chk("face_entry", oData_RES, 32'h4024_ABCD);
        step(1, 0, '0, '0, 0, 0);
        step(1, 0, '0, '0, 0, 0);
        chk("stage_two", 32'(oStage), 32'd2);
        step(0, 0, '0, '0, 0, 0);
        chk("fail_stage", 32'(oStage), 32'd0);
        chk("fail_nw", 32'(oNext_Window), 32'd1);
        chk("fail_count", 32'(oFace_Count), 32'd1);
        for (int i = 0; i < 65; i++) accept(13'(i + 100), 32'(i * 7 + 3), 0, 0);
        chk("ovf_used", 32'(oUsedw_RES), 32'd64);
        chk("ovf_flag", 32'(oOverflow), 32'd1);
        chk("ovf_count", 32'(oFace_Count), 32'd66);
        iFrame_End = 1;
        cycle();
        clr();
        repeat (3) cycle();
        chk("mark_hold_done", 32'(oFrame_Done), 32'd0);
        chk("mark_hold_used", 32'(oUsedw_RES), 32'd64);
        pop();
        cycle();
        chk("mark_done", 32'(oFrame_Done), 32'd1);
        for (int i = 0; i < 64; i++) pop();
        chk("marker_66", oData_RES, 32'hC000_0042);
        start();
        for (int i = 0; i < 10; i++) accept(13'(i + 500), 32'(32'hBEEF_0000 + i), 0, 0);
        chk("used_10", 32'(oUsedw_RES), 32'd10);
        accept(13'h1ABC, 32'h1234_5678, 0, 1);
        chk("push_pop_used", 32'(oUsedw_RES), 32'd10);
        accept(13'h0777, 32'h0000_0F0F, 1, 0);
        cycle();
        chk("fe_used", 32'(oUsedw_RES), 32'd12);
        for (int i = 0; i < 12; i++) pop();
        chk("marker_12", oData_RES, 32'hC000_000C);
        start();
        for (int i = 0; i < 3; i++) accept(13'(i + 9), 32'(i + 1), 0, 0);
        chk("pre_reset_used", 32'(oUsedw_RES), 32'd3);
        step(1, 0, '0, '0, 0, 0);
        iReset = 1;
        iWrreq_OM = 1;
        iAddr_OM = 13'h55;
        iData_OM = 32'h5555_5555;
        cycle();
        clr();
        chk("rst_empty", 32'(oEmpty_RES), 32'd1);
        chk("rst_count", 32'(oFace_Count), 32'd0);
        chk("rst_wren", 32'(oWren_OM), 32'd0);
        step(1, 0, '0, '0, 0, 0);
        chk("idle_ignore", 32'(oStage), 32'd0);
        repeat (2) cycle();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
